// File: rtl/gt_miss_ctrl_if.sv
// Bus bundle between the fetch unit / memory side and the miss controller.
// The master side presents lookups and memory data. The slave side is the
// controller, which returns stall, strobes, fill data and statistics.
interface gt_miss_ctrl_if #(
  parameter int LINE_W = 256,
  parameter int SAT_W  = 16
);
  logic              lookup_valid;
  logic [31:0]       lookup_addr;
  logic              dm_hit;
  logic              victim_hit;
  logic              dm_slot_valid;
  logic [LINE_W-1:0] mem_rdata;
  logic              stall;
  logic              mem_req;
  logic [26:0]       mem_line_addr;
  logic              swap_en;
  logic              evict_en;
  logic              fill_en;
  logic [LINE_W-1:0] fill_data;
  logic [26:0]       fill_line_addr;
  logic [SAT_W-1:0]  hit_count;
  logic [SAT_W-1:0]  miss_count;
  logic              busy;

  modport master (
    output lookup_valid, lookup_addr, dm_hit, victim_hit, dm_slot_valid, mem_rdata,
    input  stall, mem_req, mem_line_addr, swap_en, evict_en, fill_en,
           fill_data, fill_line_addr, hit_count, miss_count, busy
  );

  modport slave (
    input  lookup_valid, lookup_addr, dm_hit, victim_hit, dm_slot_valid, mem_rdata,
    output stall, mem_req, mem_line_addr, swap_en, evict_en, fill_en,
           fill_data, fill_line_addr, hit_count, miss_count, busy
  );
endinterface

// File: rtl/gt_miss_ctrl.sv
// Miss controller for a direct-mapped instruction cache with a victim buffer.
// Hits in the direct map cost nothing. Victim hits take a single swap cycle.
// Misses issue one fixed-latency memory request, optionally evict the
// displaced line, then fill. All strobes and status are registered; only
// stall is combinational so the fetch unit can freeze in the lookup cycle.
module gt_miss_ctrl #(
  parameter int MEM_LATENCY = 4,
  parameter int LINE_W      = 256,
  parameter int SAT_W       = 16
) (
  input  logic           CLK,
  input  logic           CLEAR_BAR,
  gt_miss_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SWAP     = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_EVICT    = 3'd3,
    ST_FILL     = 3'd4
  } state_t;

  localparam logic [3:0] LAT_C = 4'(MEM_LATENCY);

  state_t            state_q;
  logic [3:0]        wait_cnt_q;
  logic              mem_req_q;
  logic              swap_en_q;
  logic              evict_en_q;
  logic              fill_en_q;
  logic              busy_q;
  logic [26:0]       line_addr_q;
  logic [LINE_W-1:0] fill_data_q;
  logic [SAT_W-1:0]  hit_cnt_q;
  logic [SAT_W-1:0]  miss_cnt_q;
  logic              unused_addr_s;

  // Saturating increment: an all-ones count stays at all-ones.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val);
    if (&val) begin
      return val;
    end else begin
      return val + SAT_W'(1);
    end
  endfunction

  // Byte offset within a line is irrelevant to the controller.
  assign unused_addr_s = ^bus.lookup_addr[4:0];

  // Controller FSM with its registered strobes, latched line data and counters.
  always_ff @(posedge CLK or negedge CLEAR_BAR) begin
    if (!CLEAR_BAR) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 4'd0;
      mem_req_q   <= 1'b0;
      swap_en_q   <= 1'b0;
      evict_en_q  <= 1'b0;
      fill_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      line_addr_q <= 27'd0;
      fill_data_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      // Strobes are one cycle wide unless re-armed below.
      mem_req_q  <= 1'b0;
      swap_en_q  <= 1'b0;
      evict_en_q <= 1'b0;
      fill_en_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.lookup_valid) begin
            if (bus.dm_hit) begin
              hit_cnt_q <= sat_inc(hit_cnt_q);
              busy_q    <= 1'b0;
            end else if (bus.victim_hit) begin
              hit_cnt_q <= sat_inc(hit_cnt_q);
              state_q   <= ST_SWAP;
              swap_en_q <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              miss_cnt_q  <= sat_inc(miss_cnt_q);
              line_addr_q <= bus.lookup_addr[31:5];
              wait_cnt_q  <= LAT_C;
              state_q     <= ST_MEM_WAIT;
              mem_req_q   <= 1'b1;
              busy_q      <= 1'b1;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_SWAP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        ST_MEM_WAIT: begin
          // The memory line is valid during the last wait cycle only.
          if (wait_cnt_q <= 4'd1) begin
            fill_data_q <= bus.mem_rdata;
            wait_cnt_q  <= 4'd0;
            if (bus.dm_slot_valid) begin
              state_q    <= ST_EVICT;
              evict_en_q <= 1'b1;
            end else begin
              state_q   <= ST_FILL;
              fill_en_q <= 1'b1;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        ST_EVICT: begin
          state_q   <= ST_FILL;
          fill_en_q <= 1'b1;
        end
        ST_FILL: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // The fetch unit must freeze in the very cycle a non-direct-map lookup is seen.
  assign bus.stall = (state_q != ST_IDLE) | (bus.lookup_valid & ~bus.dm_hit);

  assign bus.mem_req        = mem_req_q;
  assign bus.swap_en        = swap_en_q;
  assign bus.evict_en       = evict_en_q;
  assign bus.fill_en        = fill_en_q;
  assign bus.busy           = busy_q;
  assign bus.mem_line_addr  = line_addr_q;
  assign bus.fill_line_addr = line_addr_q;
  assign bus.fill_data      = fill_data_q;
  assign bus.hit_count      = hit_cnt_q;
  assign bus.miss_count     = miss_cnt_q;

endmodule

// File: tb/tb_gt_miss_ctrl.sv
// Directed bench for gt_miss_ctrl: a cycle-by-cycle vector table for the
// main hit/miss flows, plus hand sequences for MEM_LATENCY=1, mid-miss
// reset and counter saturation.
module tb_gt_miss_ctrl;
  localparam int LINE_W = 256;
  localparam int SAT_W  = 16;
  localparam logic [LINE_W-1:0] PAT_A = {8{32'hCAFE_0A0A}};
  localparam logic [LINE_W-1:0] PAT_B = {8{32'h1234_5678}};
  localparam logic [LINE_W-1:0] JUNK  = {8{32'hDEAD_BEEF}};
  localparam logic [31:0] ADDR_A = 32'h0000_1240;
  localparam logic [31:0] ADDR_V = 32'h0000_5000;
  localparam logic [26:0] LINE_A = 27'h92;

  logic CLK;
  logic CLEAR_BAR;
  int   n_vec;
  int   n_err;

  gt_miss_ctrl_if #(.LINE_W(LINE_W), .SAT_W(SAT_W)) bus0 ();
  gt_miss_ctrl_if #(.LINE_W(LINE_W), .SAT_W(SAT_W)) bus1 ();

  gt_miss_ctrl #(.MEM_LATENCY(4), .LINE_W(LINE_W), .SAT_W(SAT_W)) dut (
    .CLK(CLK), .CLEAR_BAR(CLEAR_BAR), .bus(bus0)
  );
  gt_miss_ctrl #(.MEM_LATENCY(1), .LINE_W(LINE_W), .SAT_W(SAT_W)) dut_l1 (
    .CLK(CLK), .CLEAR_BAR(CLEAR_BAR), .bus(bus1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One table row = one clock cycle: inputs driven, then outputs compared.
  // in  = {lookup_valid, dm_hit, victim_hit, dm_slot_valid}
  // out = {stall, mem_req, swap_en, evict_en, fill_en, busy}
  typedef struct {
    logic [3:0]        in;
    logic [31:0]       addr;
    logic [LINE_W-1:0] rdata;
    logic [5:0]        out;
    logic [SAT_W-1:0]  hit;
    logic [SAT_W-1:0]  miss;
    logic [26:0]       line;
    logic [LINE_W-1:0] fd;
  } vec_t;

  vec_t tbl[21];

  function automatic logic [LINE_W-1:0] pat(input int sel);
    case (sel)
      1:       return PAT_A;
      2:       return PAT_B;
      default: return JUNK;
    endcase
  endfunction

  function automatic vec_t mk(input logic [3:0] in, input logic [31:0] addr, input int rs,
                              input logic [5:0] out, input logic [SAT_W-1:0] hit,
                              input logic [SAT_W-1:0] miss, input logic [26:0] line,
                              input int fs);
    vec_t r;
    r.in    = in;
    r.addr  = addr;
    r.rdata = pat(rs);
    r.out   = out;
    r.hit   = hit;
    r.miss  = miss;
    r.line  = line;
    r.fd    = (fs == 0) ? '0 : pat(fs);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive0(input logic [3:0] in, input logic [31:0] addr, input logic [LINE_W-1:0] rd);
    bus0.lookup_valid  = in[3];
    bus0.dm_hit        = in[2];
    bus0.victim_hit    = in[1];
    bus0.dm_slot_valid = in[0];
    bus0.lookup_addr   = addr;
    bus0.mem_rdata     = rd;
  endtask

  task automatic drive1(input logic [3:0] in, input logic [31:0] addr, input logic [LINE_W-1:0] rd);
    bus1.lookup_valid  = in[3];
    bus1.dm_hit        = in[2];
    bus1.victim_hit    = in[1];
    bus1.dm_slot_valid = in[0];
    bus1.lookup_addr   = addr;
    bus1.mem_rdata     = rd;
  endtask

  function automatic logic [5:0] strobes0();
    return {bus0.stall, bus0.mem_req, bus0.swap_en, bus0.evict_en, bus0.fill_en, bus0.busy};
  endfunction

  function automatic logic [5:0] strobes1();
    return {bus1.stall, bus1.mem_req, bus1.swap_en, bus1.evict_en, bus1.fill_en, bus1.busy};
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    drive0(4'b0000, 32'd0, JUNK);
    drive1(4'b0000, 32'd0, JUNK);

    // Miss at 0x1240, no eviction: 6 stall cycles, fill with PAT_A.
    tbl[0]  = mk(4'b0000, 32'd0,         0, 6'b000000, 16'd0, 16'd0, 27'd0,  0);
    tbl[1]  = mk(4'b1000, ADDR_A,        0, 6'b100000, 16'd0, 16'd0, 27'd0,  0);
    tbl[2]  = mk(4'b1110, ADDR_A,        0, 6'b110001, 16'd0, 16'd1, LINE_A, 0);
    tbl[3]  = mk(4'b0000, 32'd0,         0, 6'b100001, 16'd0, 16'd1, LINE_A, 0);
    tbl[4]  = mk(4'b1000, 32'hFFFF_FFE0, 0, 6'b100001, 16'd0, 16'd1, LINE_A, 0);
    tbl[5]  = mk(4'b1000, ADDR_A,        1, 6'b100001, 16'd0, 16'd1, LINE_A, 0);
    tbl[6]  = mk(4'b1000, ADDR_A,        0, 6'b100011, 16'd0, 16'd1, LINE_A, 1);
    tbl[7]  = mk(4'b1100, ADDR_A,        0, 6'b000000, 16'd0, 16'd1, LINE_A, 1);
    // Same miss with a valid slot: evict precedes fill, 7 stall cycles.
    tbl[8]  = mk(4'b1000, ADDR_A,        0, 6'b100000, 16'd1, 16'd1, LINE_A, 1);
    tbl[9]  = mk(4'b1000, ADDR_A,        0, 6'b110001, 16'd1, 16'd2, LINE_A, 1);
    tbl[10] = mk(4'b1000, ADDR_A,        0, 6'b100001, 16'd1, 16'd2, LINE_A, 1);
    tbl[11] = mk(4'b1000, ADDR_A,        0, 6'b100001, 16'd1, 16'd2, LINE_A, 1);
    tbl[12] = mk(4'b1001, ADDR_A,        2, 6'b100001, 16'd1, 16'd2, LINE_A, 1);
    tbl[13] = mk(4'b1001, ADDR_A,        0, 6'b100101, 16'd1, 16'd2, LINE_A, 2);
    tbl[14] = mk(4'b1000, ADDR_A,        0, 6'b100011, 16'd1, 16'd2, LINE_A, 2);
    tbl[15] = mk(4'b0000, 32'd0,         0, 6'b000000, 16'd1, 16'd2, LINE_A, 2);
    // Victim hit: one swap cycle, 2 stall cycles, no memory request.
    tbl[16] = mk(4'b1010, ADDR_V,        0, 6'b100000, 16'd1, 16'd2, LINE_A, 2);
    tbl[17] = mk(4'b1010, ADDR_V,        0, 6'b101001, 16'd2, 16'd2, LINE_A, 2);
    tbl[18] = mk(4'b0000, 32'd0,         0, 6'b000000, 16'd2, 16'd2, LINE_A, 2);
    // Direct-map and victim hit together: plain hit, no swap.
    tbl[19] = mk(4'b1110, ADDR_V,        0, 6'b000000, 16'd2, 16'd2, LINE_A, 2);
    tbl[20] = mk(4'b0000, 32'd0,         0, 6'b000000, 16'd3, 16'd2, LINE_A, 2);

    // Asynchronous reset before any clock edge.
    CLEAR_BAR = 1'b1;
    #2 CLEAR_BAR = 1'b0;
    #2;
    chk("reset strobes", LINE_W'(strobes0()), LINE_W'(6'b000000));
    chk("reset hit", LINE_W'(bus0.hit_count), LINE_W'(16'd0));
    chk("reset miss", LINE_W'(bus0.miss_count), LINE_W'(16'd0));
    chk("reset line", LINE_W'(bus0.mem_line_addr), LINE_W'(27'd0));
    chk("reset fill_data", bus0.fill_data, '0);
    #18 CLEAR_BAR = 1'b1;
    @(posedge CLK);
    #1;

    // Table-driven main flows.
    for (int i = 0; i < 21; i++) begin
      drive0(tbl[i].in, tbl[i].addr, tbl[i].rdata);
      #2;
      chk($sformatf("row%0d strobes", i), LINE_W'(strobes0()), LINE_W'(tbl[i].out));
      chk($sformatf("row%0d hit", i), LINE_W'(bus0.hit_count), LINE_W'(tbl[i].hit));
      chk($sformatf("row%0d miss", i), LINE_W'(bus0.miss_count), LINE_W'(tbl[i].miss));
      chk($sformatf("row%0d mem_line", i), LINE_W'(bus0.mem_line_addr), LINE_W'(tbl[i].line));
      chk($sformatf("row%0d fill_line", i), LINE_W'(bus0.fill_line_addr), LINE_W'(tbl[i].line));
      chk($sformatf("row%0d fill_data", i), bus0.fill_data, tbl[i].fd);
      @(posedge CLK);
      #1;
    end

    // MEM_LATENCY=1: the single wait cycle requests and captures.
    drive1(4'b1000, 32'h0000_0FE0, JUNK);
    #2;
    chk("l1 lookup", LINE_W'(strobes1()), LINE_W'(6'b100000));
    @(posedge CLK);
    #1;
    drive1(4'b0000, 32'd0, PAT_B);
    #2;
    chk("l1 wait", LINE_W'(strobes1()), LINE_W'(6'b110001));
    chk("l1 line", LINE_W'(bus1.mem_line_addr), LINE_W'(27'h7F));
    chk("l1 miss", LINE_W'(bus1.miss_count), LINE_W'(16'd1));
    @(posedge CLK);
    #1;
    drive1(4'b0000, 32'd0, JUNK);
    #2;
    chk("l1 fill", LINE_W'(strobes1()), LINE_W'(6'b100011));
    chk("l1 fill_data", bus1.fill_data, PAT_B);
    @(posedge CLK);
    #1;
    chk("l1 idle", LINE_W'(strobes1()), LINE_W'(6'b000000));

    // Reset pulsed during MEM_WAIT cycle 2 aborts the miss.
    drive0(4'b1000, ADDR_A, JUNK);
    @(posedge CLK);
    #1;
    drive0(4'b0000, 32'd0, JUNK);
    @(posedge CLK);
    #2 CLEAR_BAR = 1'b0;
    #1;
    chk("abort strobes", LINE_W'(strobes0()), LINE_W'(6'b000000));
    chk("abort miss", LINE_W'(bus0.miss_count), LINE_W'(16'd0));
    chk("abort hit", LINE_W'(bus0.hit_count), LINE_W'(16'd0));
    chk("abort line", LINE_W'(bus0.fill_line_addr), LINE_W'(27'd0));
    chk("abort fill_data", bus0.fill_data, '0);
    @(posedge CLK);
    #3 CLEAR_BAR = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("post-abort cyc%0d", i), LINE_W'({bus0.fill_en, bus0.busy}), LINE_W'(2'b00));
    end
    // Fresh lookup after release is an ordinary miss.
    drive0(4'b1000, ADDR_A, JUNK);
    #1;
    chk("fresh stall", LINE_W'(bus0.stall), LINE_W'(1'b1));
    @(posedge CLK);
    #1;
    drive0(4'b0000, 32'd0, PAT_A);
    #1;
    chk("fresh req", LINE_W'(strobes0()), LINE_W'(6'b110001));
    chk("fresh miss", LINE_W'(bus0.miss_count), LINE_W'(16'd1));
    repeat (4) @(posedge CLK);
    #1;
    chk("fresh fill", LINE_W'(strobes0()), LINE_W'(6'b100011));
    chk("fresh fill_data", bus0.fill_data, PAT_A);
    @(posedge CLK);
    #1;

    // Hit counter saturation.
    drive0(4'b1100, ADDR_A, JUNK);
    repeat (65534) @(posedge CLK);
    #1;
    chk("sat fffe", LINE_W'(bus0.hit_count), LINE_W'(16'hFFFE));
    @(posedge CLK);
    #1;
    chk("sat ffff", LINE_W'(bus0.hit_count), LINE_W'(16'hFFFF));
    @(posedge CLK);
    #1;
    chk("sat hold", LINE_W'(bus0.hit_count), LINE_W'(16'hFFFF));
    chk("sat miss", LINE_W'(bus0.miss_count), LINE_W'(16'd1));
    drive0(4'b0000, 32'd0, JUNK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gt_miss_ctrl.md
GT_MISS_CTRL -- requirements
Module: gt_miss_ctrl

Interface
REQ-001 Parameters SHALL be, one per line, name, default, meaning:
  MEM_LATENCY, 4, cycles from mem_req until mem_rdata is valid; legal range 1..15.
  LINE_W, 256, line width in bits.
  SAT_W, 16, width of the hit and miss counters.
REQ-002 Ports SHALL be, one per line, name, direction, width, meaning:
  CLK  in  1  single clock, rising edge.
  CLEAR_BAR  in  1  reset, asynchronous, active-low.
  lookup_valid  in  1  fetch unit presents lookup_addr this cycle.
  lookup_addr  in  32  byte address of the fetch.
  dm_hit  in  1  direct-map tag match for lookup_addr.
  victim_hit  in  1  victim-buffer tag match for lookup_addr.
  dm_slot_valid  in  1  indexed direct-map slot holds a valid line.
  mem_rdata  in  LINE_W  line returned by the fixed-latency memory.
  stall  out  1  gates the fetch-unit clock enable; 1 = hold address.
  mem_req  out  1  one-cycle line request to memory.
  mem_line_addr  out  27  line address, lookup_addr[31:5].
  swap_en  out  1  one-cycle swap of victim line into direct map.
  evict_en  out  1  one-cycle move of the displaced direct-map line into the victim buffer.
  fill_en  out  1  one-cycle write of fill_data into the direct map.
  fill_data  out  LINE_W  buffered memory line.
  fill_line_addr  out  27  line address being filled.
  hit_count  out  SAT_W  saturating hit count.
  miss_count  out  SAT_W  saturating miss count.
  busy  out  1  1 when state is not IDLE.

Function
REQ-003 FSM states SHALL be IDLE, SWAP, MEM_WAIT, EVICT and FILL.
REQ-004 IDLE with lookup_valid=1 and dm_hit=1 SHALL stay in IDLE and increment hit_count; victim_hit is ignored.
REQ-005 IDLE with lookup_valid=1, dm_hit=0 and victim_hit=1 SHALL go to SWAP and increment hit_count.
REQ-006 IDLE with lookup_valid=1, dm_hit=0 and victim_hit=0 SHALL go to MEM_WAIT:
  - increment miss_count;
  - latch lookup_addr[31:5] into mem_line_addr and fill_line_addr;
  - load the wait counter with MEM_LATENCY.
REQ-007 SWAP SHALL assert swap_en for exactly one cycle and then return to IDLE.
REQ-008 MEM_WAIT SHALL last exactly MEM_LATENCY cycles.
  - mem_req=1 in the first cycle only.
  - The wait counter decrements once per cycle.
REQ-009 At the edge ending the last MEM_WAIT cycle, the block SHALL capture mem_rdata into fill_data.
  - Next state is EVICT if dm_slot_valid=1, else FILL.
REQ-010 EVICT SHALL assert evict_en for one cycle, then go to FILL.
REQ-011 FILL SHALL assert fill_en for one cycle with fill_data and fill_line_addr stable, then return to IDLE.
REQ-012 stall SHALL be combinational: (state != IDLE) OR (state == IDLE AND lookup_valid AND NOT dm_hit).
REQ-013 lookup_valid, dm_hit, victim_hit and lookup_addr SHALL be ignored outside IDLE.
  - No counter changes outside IDLE.
  - No re-request outside IDLE.
REQ-014 Stall length SHALL be:
  - dm hit: 0 cycles;
  - victim hit: 2 cycles;
  - miss without eviction: MEM_LATENCY+2 cycles;
  - miss with eviction: MEM_LATENCY+3 cycles.
REQ-015 hit_count and miss_count SHALL saturate at all-ones and never wrap.
REQ-016 At most one of mem_req, swap_en, evict_en and fill_en SHALL be high in any cycle.
REQ-017 mem_line_addr and fill_line_addr SHALL hold their latched value until the next miss.
REQ-018 fill_data SHALL hold its value until the next capture.
REQ-019 When MEM_LATENCY=1, MEM_WAIT SHALL be a single cycle that both asserts mem_req and captures mem_rdata.

Reset
REQ-020 CLEAR_BAR=0 SHALL immediately, without waiting for CLK, force:
  - state to IDLE;
  - all one-cycle strobes and busy to 0;
  - counters, fill_data and both line addresses to 0.
REQ-021 Reset asserted mid-MEM_WAIT, mid-EVICT or mid-FILL SHALL abort the operation.
  - No fill_en follows reset release.
  - The first lookup after release is handled as a fresh IDLE lookup.
REQ-022 Reset deassertion SHALL be taken synchronously on the next CLK rising edge.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  - MEM_LATENCY=4; miss at 0x0000_1240 with dm_slot_valid=0 -> mem_req for 1 cycle, mem_line_addr=0x92, stall high 6 cycles, fill_en for 1 cycle with the mem_rdata pattern, miss_count=1.
  - Same miss with dm_slot_valid=1 -> evict_en the cycle before fill_en, stall high 7 cycles.
  - dm_hit=0, victim_hit=1 -> swap_en for 1 cycle, stall high 2 cycles, hit_count=1, mem_req never asserted.
  - dm_hit=1 and victim_hit=1 together -> no stall, no swap_en, hit_count increments.
  - CLEAR_BAR pulsed low in MEM_WAIT cycle 2 -> busy=0 and miss_count=0 at once, and no fill_en afterwards.
  - Counters preset near saturation by 0xFFFF hits -> hit_count stays 0xFFFF after a further hit.
